// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-step multiply / restoring divide with hi/lo result registers.
// Latency: done pulses DATA_WIDTH+1 edges after the start edge; hi/lo load on that same edge.
// Backpressure: start is ignored while busy; a new start is taken on the edge that leaves DONE.
// Build option: define MUL_DIV_UNIT_DIV_EN to include the divide datapath. Without it, the
// divide ops keep the same timing and load hi=lo=0.
module mul_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] busA,
    input  logic [DATA_WIDTH-1:0] busB,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;          // product / quotient needs negation
    logic [W-1:0]    opnd_q, opnd_d;        // multiplicand or divisor magnitude
    logic [2*W-1:0]  acc_q, acc_d;          // {upper, lower} shift accumulator
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    logic            a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next, prod;

    assign a_neg = op[0] & busA[W-1];
    assign b_neg = op[0] & busB[W-1];
    assign a_mag = a_neg ? -busA : busA;
    assign b_mag = b_neg ? -busB : busB;

    // Shift-add: add multiplicand to the upper half when the current multiplier bit is set
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[W-1:1]};
    assign prod     = neg_q ? -acc_q : acc_q;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic            neg_rem_q, neg_rem_d;  // remainder follows dividend sign
    logic            div0_q, div0_d;        // divisor was zero; opnd_q holds raw dividend
    logic [W:0]      rem_sh, rem_diff;
    logic            q_bit;
    logic [W-1:0]    rem_new, quo, rem;
    logic [2*W-1:0]  div_next;

    // Restoring step: shift one dividend bit into the remainder, subtract if it fits
    assign rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
    assign rem_diff = rem_sh - {1'b0, opnd_q};
    assign q_bit    = ~rem_diff[W];
    assign rem_new  = q_bit ? rem_diff[W-1:0] : rem_sh[W-1:0];
    assign div_next = {rem_new, acc_q[W-2:0], q_bit};
    assign quo      = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem      = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
`endif

    // Next-state, datapath step and result load
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MUL_DIV_UNIT_DIV_EN
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    neg_d    = a_neg ^ b_neg;
                    opnd_d   = a_mag;
                    acc_d    = {{W{1'b0}}, b_mag};
`ifdef MUL_DIV_UNIT_DIV_EN
                    neg_rem_d = a_neg;
                    div0_d    = op[1] && (busB == '0);
                    if (op[1]) begin
                        opnd_d = (busB == '0) ? busA : b_mag;
                        acc_d  = {{W{1'b0}}, a_mag};
                    end
`endif
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    hi_d    = prod[2*W-1:W];
                    lo_d    = prod[W-1:0];
                    if (is_div_q) begin
`ifdef MUL_DIV_UNIT_DIV_EN
                        hi_d = div0_q ? opnd_q : rem;
                        lo_d = div0_q ? '1 : quo;
`else
                        hi_d = '0;
                        lo_d = '0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    acc_d = mul_next;
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (is_div_q) acc_d = div_next;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    // Divide sign and zero-divisor flags
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] busA, busB;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.DATA_WIDTH(32)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .op(op),
        .busA(busA), .busB(busB), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference: plain arithmetic on the operands
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = longint'(sa) * longint'(sb); eh = p[63:32]; el = p[31:0]; end
            default: begin
`ifdef MUL_DIV_UNIT_DIV_EN
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF; eh = a;
                end else if (o == 2'b10) begin
                    el = a / b; eh = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = 32'd0;
                end else begin
                    el = sa / sb; eh = sa % sb;
                end
`else
                el = '0; eh = '0;
`endif
            end
        endcase
    endfunction

    // Issue one op (called #1 after an edge), optionally poke start mid-CALC, check latency and result
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, input string name);
        logic [31:0] eh, el;
        int n;
        bit seen;
        model(o, a, b, eh, el);
        op = o; busA = a; busB = b; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0; op = 2'($urandom); busA = $urandom; busB = $urandom;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            if (inject && n == 5) begin start = 1'b1; op = 2'b11; busA = $urandom; busB = $urandom; end
            if (inject && n == 7) start = 1'b0;
            @(posedge sys_clk); #1;
            n++;
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != 33) begin
            errors++; $display("FAIL %s latency: got %0d edges (seen=%0d) want 33", name, n, seen);
        end
        checks++;
        if (hi !== eh) begin errors++; $display("FAIL %s hi: got %h want %h", name, hi, eh); end
        checks++;
        if (lo !== el) begin errors++; $display("FAIL %s lo: got %h want %h", name, lo, el); end
    endtask

    task automatic wait_idle(input string name);
        @(posedge sys_clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL %s idle: got busy=%b done=%b want 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; start = 1'b0; op = 2'b00; busA = '0; busB = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL reset hilo: got %h/%h want 0/0", hi, lo);
        end
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_mul();
        run_op(2'b00, 32'h0000_FFFF, 32'h0001_0001, 0, "umul");
        wait_idle("umul");
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1, "smul_ignore_start");
        wait_idle("smul_ignore_start");
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, "smul_minmin");
        wait_idle("smul_minmin");
    endtask

    task automatic test_div();
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, "sdiv");
        wait_idle("sdiv");
        run_op(2'b10, 32'd100, 32'd0, 0, "udiv_by0");
        wait_idle("udiv_by0");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, "sdiv_ovf");
        wait_idle("sdiv_ovf");
        run_op(2'b11, 32'hFFFF_FFF0, 32'd0, 0, "sdiv_by0");
        wait_idle("sdiv_by0");
        run_op(2'b10, 32'd100, 32'd7, 0, "udiv");
        run_op(2'b00, 32'd6, 32'd7, 0, "mul_after_div");
        wait_idle("mul_after_div");
    endtask

    // Next start presented during DONE is taken on the edge that leaves DONE
    task automatic test_back_to_back();
        run_op(2'($urandom), $urandom, $urandom, 0, "b2b_first");
        run_op(2'($urandom), $urandom, $urandom_range(1, 1000), 0, "b2b_second");
        wait_idle("b2b_second");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 20; i++) begin
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: b = $urandom;
            endcase
            run_op(2'($urandom), a, b, 0, "random");
            wait_idle("random");
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        op = 2'b00; busA = 32'h1234_5678; busB = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge sys_clk); #1;
            if (done === 1'b1) dones++;
        end
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset ctrl: got busy=%b done=%b want 0 0", busy, done);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++; $display("FAIL midreset hilo: got %h/%h want 0/0", hi, lo);
        end
        repeat (40) begin
            @(posedge sys_clk); #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++; $display("FAIL midreset quiet: got %0d busy/done cycles want 0", dones);
        end
        run_op(2'b00, 32'd6, 32'd7, 0, "mul_after_reset");
        wait_idle("mul_after_reset");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
